// File: rtl/display_pkg.sv
// Shared 7-segment types and glyph constants for the display path.
// Segment order is bit6=a ... bit0=g, with 1 meaning the segment is lit.
package display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b0000000;

    localparam seg7_t SEG_DIGIT [0:9] = '{
        7'b1111110,  // 0
        7'b0110000,  // 1
        7'b1101101,  // 2
        7'b1111001,  // 3
        7'b0110011,  // 4
        7'b1011011,  // 5
        7'b1011111,  // 6
        7'b1110000,  // 7
        7'b1111111,  // 8
        7'b1111011   // 9
    };

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational BCD digit to 7-segment decoder.
// Non-BCD codes 10-15 decode to an unlit glyph.
module bcd_to_7seg
    import display_pkg::*;
(
    input  logic [3:0] bcd,
    output seg7_t      seg
);

    always_comb begin
        seg = SEG_BLANK;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGIT[bcd];
        end
    end

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed 7-segment scan driver with slot-start blanking and
// per-digit blink; all outputs are registered one cycle behind the scan state.
module display_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 1,
    parameter int BLINK_DIV    = 250
)(
    input  logic                    in_clk,
    input  logic                    in_reset,
    input  logic                    in_enable,
    input  logic [4*NUM_DIGITS-1:0] in_digits,
    input  logic [NUM_DIGITS-1:0]   in_blink_mask,
    output logic [6:0]              out_segments,
    output logic [NUM_DIGITS-1:0]   out_digit_en,
    output logic                    out_frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST   = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] PRE_BLANK  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    logic [PW-1:0]         prescaler_reg, prescaler_next;
    logic [IW-1:0]         idx_reg, idx_next;
    logic [FW-1:0]         frame_cnt_reg, frame_cnt_next;
    logic                  blink_phase_reg, blink_phase_next;
    seg7_t                 seg_reg, seg_next;
    logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
    logic                  frame_done_reg, frame_done_next;

    logic                  tick;
    logic                  frame_wrap;
    logic [3:0]            digit_arr [NUM_DIGITS];
    logic [3:0]            nibble;
    seg7_t                 decoded;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit_arr[gi] = in_digits[4*gi +: 4];
        end
    endgenerate

    assign nibble = digit_arr[idx_reg];

    bcd_to_7seg u_decode (
        .bcd (nibble),
        .seg (decoded)
    );

    always_comb begin
        tick             = in_enable && (prescaler_reg == PRE_LAST);
        frame_wrap       = tick && (idx_reg == IDX_LAST);

        prescaler_next   = prescaler_reg;
        idx_next         = idx_reg;
        frame_cnt_next   = frame_cnt_reg;
        blink_phase_next = blink_phase_reg;
        digit_en_next    = '0;
        seg_next         = SEG_BLANK;
        frame_done_next  = frame_wrap;

        // A disabled scan holds every counter so re-enable resumes mid-slot.
        if (in_enable) begin
            prescaler_next = tick ? '0 : prescaler_reg + 1'b1;
        end

        if (tick) begin
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end

        if (frame_wrap) begin
            if (frame_cnt_reg == FRAME_LAST) begin
                frame_cnt_next   = '0;
                blink_phase_next = ~blink_phase_reg;
            end else begin
                frame_cnt_next = frame_cnt_reg + 1'b1;
            end
        end

        // Early slot cycles keep all enables low so the previous glyph cannot ghost.
        if (in_enable) begin
            if (prescaler_reg >= PRE_BLANK) begin
                digit_en_next = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx_reg;
            end
            if (!(in_blink_mask[idx_reg] && blink_phase_reg)) begin
                seg_next = decoded;
            end
        end
    end

    always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
            prescaler_reg   <= '0;
            idx_reg         <= '0;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b0;
            seg_reg         <= SEG_BLANK;
            digit_en_reg    <= '0;
            frame_done_reg  <= 1'b0;
        end else begin
            prescaler_reg   <= prescaler_next;
            idx_reg         <= idx_next;
            frame_cnt_reg   <= frame_cnt_next;
            blink_phase_reg <= blink_phase_next;
            seg_reg         <= seg_next;
            digit_en_reg    <= digit_en_next;
            frame_done_reg  <= frame_done_next;
        end
    end

    assign out_segments   = seg_reg;
    assign out_digit_en   = digit_en_reg;
    assign out_frame_done = frame_done_reg;

endmodule
